// File: rtl/sound_sequencer_if.sv
// Game-FSM to sound-sequencer link: trigger/code from the game side,
// audio line and playback status back from the sequencer.
interface sound_sequencer_if;
    logic       enable_sound;
    logic [9:0] sound_freq_in;
    logic       audio_out;
    logic       busy;
    logic [1:0] note_index;
    logic       done_pulse;

    modport master (
        output enable_sound, sound_freq_in,
        input  audio_out, busy, note_index, done_pulse
    );

    modport slave (
        input  enable_sound, sound_freq_in,
        output audio_out, busy, note_index, done_pulse
    );
endinterface

// File: rtl/sound_sequencer.sv
// Plays a WIN (LO,MID,HI) or LOSE (HI,LO) melody as a square wave on the
// rising edge of enable_sound; reports busy, current note and completion.
module sound_sequencer #(
    parameter int unsigned NOTE_LEN = 12500000,
    parameter int unsigned GAP_LEN  = 2500000,
    parameter int unsigned DIV_LO   = 95556,
    parameter int unsigned DIV_MID  = 63776,
    parameter int unsigned DIV_HI   = 47778
) (
    input  logic             clk,
    input  logic             resetN,
    sound_sequencer_if.slave snd
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NOTE = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [26:0] NOTE_END = 27'(NOTE_LEN - 1);
    localparam logic [26:0] GAP_END  = 27'(GAP_LEN - 1);
    localparam logic [16:0] LO_END   = 17'(DIV_LO - 1);
    localparam logic [16:0] MID_END  = 17'(DIV_MID - 1);
    localparam logic [16:0] HI_END   = 17'(DIV_HI - 1);
    localparam bit          HAS_GAP  = (GAP_LEN != 0);

    logic [1:0]  state;
    logic        en_hist;
    logic        win;
    logic        audio;
    logic [1:0]  idx;
    logic [26:0] dur_cnt;
    logic [16:0] tone_cnt;

    logic        trig;
    logic        code_ok;
    logic        last_note;
    logic [16:0] div_end;

    // History resets high so a level already high at reset release is not an edge.
    assign trig    = snd.enable_sound & ~en_hist;
    assign code_ok = (snd.sound_freq_in == 10'd0) || (snd.sound_freq_in == 10'd1);

    always_comb begin
        div_end = LO_END;
        if (win) begin
            case (idx)
                2'd0:    div_end = LO_END;
                2'd1:    div_end = MID_END;
                default: div_end = HI_END;
            endcase
        end else begin
            div_end = (idx == 2'd0) ? HI_END : LO_END;
        end
    end

    assign last_note = win ? (idx == 2'd2) : (idx == 2'd1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            en_hist  <= 1'b1;
            win      <= 1'b0;
            audio    <= 1'b0;
            idx      <= 2'd0;
            dur_cnt  <= '0;
            tone_cnt <= '0;
        end else begin
            en_hist <= snd.enable_sound;
            case (state)
                IDLE: begin
                    if (trig && code_ok) begin
                        win      <= snd.sound_freq_in[0];
                        state    <= NOTE;
                        idx      <= 2'd0;
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        audio    <= 1'b0;
                    end
                end
                NOTE: begin
                    if (dur_cnt == NOTE_END) begin
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        audio    <= 1'b0;
                        if (last_note) begin
                            state <= DONE;
                            idx   <= 2'd0;
                        end else if (HAS_GAP) begin
                            state <= GAP;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        dur_cnt <= dur_cnt + 27'd1;
                        if (tone_cnt == div_end) begin
                            tone_cnt <= '0;
                            audio    <= ~audio;
                        end else begin
                            tone_cnt <= tone_cnt + 17'd1;
                        end
                    end
                end
                GAP: begin
                    // Tone counter and audio were already cleared on entry.
                    if (dur_cnt == GAP_END) begin
                        state   <= NOTE;
                        idx     <= idx + 2'd1;
                        dur_cnt <= '0;
                    end else begin
                        dur_cnt <= dur_cnt + 27'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign snd.audio_out  = audio;
    assign snd.busy       = (state == NOTE) || (state == GAP);
    assign snd.note_index = idx;
    assign snd.done_pulse = (state == DONE);

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
Receiving end of the game sound interface: consumes the enable_sound / sound_freq handshake from the game FSM and plays a short melody on a 1-bit square-wave audio line. Code 1 (WIN) plays a rising three-note melody and code 0 (LOSE) plays a falling two-note melody. It sits between the game controller and the board speaker/audio pin, and reports busy/done status.

Parameters:
NOTE_LEN, 12500000, cycles each note sounds (0.25 s at 50 MHz); valid range 1..2^27-1
GAP_LEN, 2500000, silent cycles between notes; 0 means no gap; valid range 0..2^27-1
DIV_LO, 95556, half-period in cycles of the low note (~261.6 Hz at 50 MHz); valid range 1..2^17-1
DIV_MID, 63776, half-period of the middle note (~392 Hz); valid range 1..2^17-1
DIV_HI, 47778, half-period of the high note (~523 Hz); valid range 1..2^17-1

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous, active-low reset
enable_sound  input  1  trigger level from the game FSM; a rising edge requests playback
sound_freq_in  input  10  melody code, sampled on the trigger edge: 0 = LOSE, 1 = WIN, other values invalid
audio_out  output  1  square-wave audio
busy  output  1  high while a melody is playing (NOTE and GAP states)
note_index  output  2  0-based index of the current note; 0 in IDLE and DONE
done_pulse  output  1  one-cycle pulse after the last note ends

Behaviour:
- Reset (asynchronous, resetN=0): state=IDLE; audio_out=0, busy=0, note_index=0, done_pulse=0; all counters=0; enable-history register=1.
- Trigger: enable_sound=1 while the history register is 0, sampled at a posedge. The history register updates every cycle.
  - Because the history register resets to 1, enable_sound held high through reset release is not a trigger. A low-then-high is required.
  - enable_sound held high for many cycles produces one trigger only.
- IDLE, on a trigger:
  - Code 0: latch the LOSE melody, notes HI then LO.
  - Code 1: latch the WIN melody, notes LO, MID, HI.
  - Any other code: ignore the trigger and stay in IDLE.
  - sound_freq_in is sampled only at the trigger; later changes have no effect.
- Latency: trigger at posedge T; from T+1, state=NOTE, busy=1, note_index=0, audio_out=0.
- NOTE state:
  - Duration counter runs 0..NOTE_LEN-1. Tone counter runs 0..DIV-1, where DIV is the current note's divisor.
  - When the tone counter reaches DIV-1, audio_out toggles and the tone counter wraps to 0. Each note therefore starts low with period 2*DIV.
  - When the duration counter reaches NOTE_LEN-1:
    - Last note: go to DONE.
    - Otherwise, GAP_LEN>0: go to GAP.
    - Otherwise (GAP_LEN=0): go to NOTE, note_index+1, counters cleared, audio_out=0.
- GAP state:
  - audio_out=0, busy=1, and note_index holds its value.
  - After GAP_LEN cycles: go to NOTE, note_index+1, counters cleared.
- DONE state:
  - Lasts one cycle: done_pulse=1, busy=0, audio_out=0, note_index=0. Then go to IDLE.
  - A trigger seen during DONE is ignored.
- Triggers while busy=1 are ignored; the melody is never restarted or truncated. The history register still tracks, so a new edge is required after returning to IDLE.
- Reset asserted mid-melody immediately forces the reset values listed above; no partial done_pulse.
- Widths:
  - Duration counter: 27 bits. Tone counter: 17 bits.
  - Comparisons are unsigned equality against parameter-1; there is no wrap beyond the terminal count.
- Total busy cycles:
  - WIN: 3*NOTE_LEN + 2*GAP_LEN.
  - LOSE: 2*NOTE_LEN + GAP_LEN.

Test Plan:
Common bench parameters: NOTE_LEN=8, GAP_LEN=2, DIV_LO=4, DIV_MID=3, DIV_HI=2.
- WIN: sound_freq_in=1, enable_sound 0->1 at T
  -> busy=1 for cycles T+1..T+28.
  -> note 0 audio_out = 0,0,0,0,1,1,1,1.
  -> note 1 audio_out = 0,0,0,1,1,1,0,0.
  -> note 2 audio_out = 0,0,1,1,0,0,1,1.
  -> audio_out=0 during both 2-cycle gaps.
  -> note_index steps 0/1/2; done_pulse=1 at T+29 only; IDLE at T+30.
- LOSE: sound_freq_in=0, trigger at T
  -> HI note (period 4), 2-cycle gap, then LO note (period 8).
  -> busy for T+1..T+18; done_pulse at T+19.
- Invalid code: sound_freq_in=5, trigger
  -> busy stays 0, audio_out stays 0, no done_pulse.
  -> A following valid edge with code 1 plays WIN normally.
- Retrigger: during WIN playback, toggle enable_sound 0->1 twice with code 0
  -> WIN completes unchanged (28 busy cycles) and no LOSE melody follows.
  -> enable_sound held high for 40 cycles from the start gives exactly one melody.
- Reset mid-note: resetN=0 at T+10 during WIN
  -> audio_out, busy, note_index and done_pulse are 0 asynchronously.
  -> After release with enable_sound still high: no playback until enable_sound goes low then high.
- GAP_LEN=0 override, code 1
  -> notes play back-to-back; busy for exactly 24 cycles; note_index changes on consecutive cycles at the 8-cycle boundaries.
